// File: rtl/req_rr_arbiter.sv
// Round-robin arbiter sharing one valid/ready request channel, with credit limits and in-order
// response steering via a tag FIFO. Define ARB_ERR_STATUS_EN to build the sticky err_o logic.
module req_rr_arbiter #(
   parameter int unsigned NUM_REQ         = 4,
   parameter int unsigned DATA_SIZE       = 16,
   parameter int unsigned MAX_OUTSTANDING = 4,
   parameter int unsigned ID_DEPTH        = 8
) (
   input  logic                           clk_i,
   input  logic                           rstn_i,
   input  logic [NUM_REQ-1:0]             req_valid_i,
   input  logic [NUM_REQ*DATA_SIZE-1:0]   req_data_i,
   output logic [NUM_REQ-1:0]             req_ready_o,
   output logic                           dn_req_valid_o,
   output logic [DATA_SIZE-1:0]           dn_req_data_o,
   input  logic                           dn_req_ready_i,
   input  logic                           dn_resp_valid_i,
   input  logic [DATA_SIZE-1:0]           dn_resp_data_i,
   output logic [NUM_REQ-1:0]             resp_valid_o,
   output logic [DATA_SIZE-1:0]           resp_data_o,
   output logic                           err_o
);

   localparam int unsigned TW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
   localparam int unsigned NW = $clog2(ID_DEPTH + 1);
   localparam int unsigned PW = (ID_DEPTH > 1) ? $clog2(ID_DEPTH) : 1;

   typedef enum logic [0:0] {StEmpty, StFull} state_e;

   state_e                 state_q;
   logic [DATA_SIZE-1:0]   data_q;
   logic [TW-1:0]          tag_q;
   logic [TW-1:0]          rr_ptr_q;
   logic [CW-1:0]          credit_q [NUM_REQ];
   logic [CW-1:0]          credit_d [NUM_REQ];
   logic [NW-1:0]          total_q, total_d;
   logic [TW-1:0]          fifo_mem [ID_DEPTH];
   logic [PW-1:0]          wr_ptr_q, rd_ptr_q;
   logic [NW-1:0]          fifo_cnt_q, fifo_cnt_d;
   logic [NUM_REQ-1:0]     resp_valid_q;
   logic [DATA_SIZE-1:0]   resp_data_q;

   logic                   load_en;
   logic [NUM_REQ-1:0]     eligible;
   logic                   grant_valid;
   logic [TW-1:0]          grant_idx;
   logic [TW-1:0]          rr_ptr_next;
   logic [NUM_REQ-1:0]     grant_oh;
   logic [DATA_SIZE-1:0]   grant_data;
   logic                   push, pop;
   logic [TW-1:0]          head_tag;
   logic [NUM_REQ-1:0]     pop_oh;
   logic [TW:0]            sum;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(ID_DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign load_en  = (state_q == StEmpty) || dn_req_ready_i;
   assign push     = (state_q == StFull) && dn_req_ready_i;
   assign pop      = dn_resp_valid_i && (fifo_cnt_q != '0);
   assign head_tag = fifo_mem[rd_ptr_q];
   assign pop_oh   = pop ? (NUM_REQ'(1) << head_tag) : '0;

   // Gated by rstn_i so req_ready_o stays low while reset is held.
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         eligible[i] = rstn_i && req_valid_i[i] && (credit_q[i] < CW'(MAX_OUTSTANDING)) &&
                       (total_q < NW'(ID_DEPTH)) && load_en;
      end
   end

   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      sum         = '0;
      for (int off = 0; off < NUM_REQ; off++) begin
         sum = {1'b0, rr_ptr_q} + (TW+1)'(off);
         if (sum >= (TW+1)'(NUM_REQ)) sum = sum - (TW+1)'(NUM_REQ);
         if (!grant_valid && eligible[sum[TW-1:0]]) begin
            grant_valid = 1'b1;
            grant_idx   = sum[TW-1:0];
         end
      end
   end

   assign grant_oh    = grant_valid ? (NUM_REQ'(1) << grant_idx) : '0;
   assign req_ready_o = grant_oh;
   assign rr_ptr_next = (grant_idx == TW'(NUM_REQ - 1)) ? '0 : grant_idx + TW'(1);

   always_comb begin
      grant_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_oh[i]) grant_data = req_data_i[i*DATA_SIZE +: DATA_SIZE];
      end
   end

   // A grant and a pop for the same requester cancel out.
   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         credit_d[i] = credit_q[i];
         if (grant_oh[i] && !pop_oh[i])      credit_d[i] = credit_q[i] + CW'(1);
         else if (pop_oh[i] && !grant_oh[i]) credit_d[i] = credit_q[i] - CW'(1);
      end
      total_d = total_q;
      if (grant_valid && !pop)      total_d = total_q + NW'(1);
      else if (pop && !grant_valid) total_d = total_q - NW'(1);
      fifo_cnt_d = fifo_cnt_q;
      if (push && !pop)      fifo_cnt_d = fifo_cnt_q + NW'(1);
      else if (pop && !push) fifo_cnt_d = fifo_cnt_q - NW'(1);
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q  <= StEmpty;
         data_q   <= '0;
         tag_q    <= '0;
         rr_ptr_q <= '0;
      end else begin
         if (grant_valid) begin
            data_q   <= grant_data;
            tag_q    <= grant_idx;
            rr_ptr_q <= rr_ptr_next;
         end
         unique case (state_q)
            StEmpty: if (grant_valid) state_q <= StFull;
            StFull:  if (dn_req_ready_i && !grant_valid) state_q <= StEmpty;
            default: state_q <= StEmpty;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         for (int i = 0; i < NUM_REQ; i++) credit_q[i] <= '0;
         total_q      <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         fifo_cnt_q   <= '0;
         resp_valid_q <= '0;
         resp_data_q  <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) credit_q[i] <= credit_d[i];
         total_q      <= total_d;
         fifo_cnt_q   <= fifo_cnt_d;
         resp_valid_q <= pop_oh;
         if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (pop) begin
            rd_ptr_q    <= ptr_inc(rd_ptr_q);
            resp_data_q <= dn_resp_data_i;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) fifo_mem[wr_ptr_q] <= tag_q;
   end

   assign dn_req_valid_o = (state_q == StFull);
   assign dn_req_data_o  = data_q;
   assign resp_valid_o   = resp_valid_q;
   assign resp_data_o    = resp_data_q;

`ifdef ARB_ERR_STATUS_EN
   logic err_q;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i)                                   err_q <= 1'b0;
      else if (dn_resp_valid_i && fifo_cnt_q == '0) err_q <= 1'b1;
   end

   assign err_o = err_q;

   grant_within_credit: assert property (@(posedge clk_i) disable iff (!rstn_i)
      !(grant_valid && credit_q[grant_idx] >= CW'(MAX_OUTSTANDING)));
`else
   assign err_o = 1'b0;
`endif

endmodule
